// File: rtl/inst_rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM loader.
package inst_rom_loader_pkg;

    localparam int INST_W = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [31:0]       inst_addr_t;

    // Loader states: two header bytes, word payload, then serving fetches.
    typedef enum logic [1:0] {
        LD_LEN_HI = 2'd0,
        LD_LEN_LO = 2'd1,
        LD_DATA   = 2'd2,
        LD_DONE   = 2'd3
    } ld_state_e;

    // True when a header word count does not fit in a RAM of 2**addr_w words.
    function automatic logic len_exceeds(input logic [LEN_W-1:0] n, input int unsigned addr_w);
        return 32'(n) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream load port plus CPU instruction-fetch port.
interface inst_rom_loader_if;
    import inst_rom_loader_pkg::*;

    logic       byte_valid_i;
    byte_t      byte_data_i;
    logic       byte_ready_o;
    logic       rom_ce_i;
    inst_addr_t rom_addr_i;
    inst_t      rom_data_o;

    // Driver side: stream source and CPU fetch unit.
    modport master (
        output byte_valid_i, byte_data_i, rom_ce_i, rom_addr_i,
        input  byte_ready_o, rom_data_o
    );

    // Loader side.
    modport slave (
        input  byte_valid_i, byte_data_i, rom_ce_i, rom_addr_i,
        output byte_ready_o, rom_data_o
    );
endinterface

// File: rtl/inst_rom_loader_ram.sv
// Instruction word RAM: synchronous write, asynchronous read, no reset.
module inst_rom_loader_ram
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  inst_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output inst_t             rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    inst_t mem_q [DEPTH];

    // Write port: one assembled word per write strobe.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_rom_loader.sv
// Loads a length-prefixed big-endian program into instruction RAM, holding the
// CPU in reset until the load finishes, then serves fetches combinationally.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    inst_rom_loader_if.slave    bus,
    input  logic                reload_i,
    output logic                cpu_rst_o,
    output logic                load_done_o,
    output logic                load_err_o,
    output logic [ADDR_W:0]     words_loaded_o
);
    ld_state_e          state_q, state_d;
    logic [1:0]         byte_idx_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [LEN_W-1:0]   len_q;
    byte_t              len_hi_q;
    logic [23:0]        asm_q;
    logic [ADDR_W:0]    words_q;
    logic               err_q;
    logic               cpu_rst_q;

    logic               byte_ready;
    logic               accept;
    logic               word_acc;
    logic               last_word;
    logic               ram_we;
    logic [LEN_W-1:0]   hdr_n;
    inst_t              ram_rdata;
    logic               unused_addr_bits;

    assign accept    = bus.byte_valid_i & byte_ready;
    assign hdr_n     = {len_hi_q, bus.byte_data_i};
    assign word_acc  = accept && (state_q == LD_DATA) && (byte_idx_q == 2'd3);
    assign last_word = word_acc && (word_cnt_q == len_q - 16'd1);
    // words_q doubles as the write pointer; its MSB marks the RAM as full.
    assign ram_we    = word_acc && !words_q[ADDR_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LD_LEN_HI;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_LEN_HI: if (accept) state_d = LD_LEN_LO;
            LD_LEN_LO: if (accept) state_d = (hdr_n == '0) ? LD_DONE : LD_DATA;
            LD_DATA:   if (last_word) state_d = LD_DONE;
            LD_DONE:   if (reload_i) state_d = LD_LEN_HI;
            default:   state_d = LD_LEN_HI;
        endcase
    end

    // State-decoded outputs; ready never looks at valid.
    always_comb begin
        byte_ready  = (state_q != LD_DONE);
        load_done_o = (state_q == LD_DONE);
    end

    // Control counters, sticky error and CPU hold-reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else if (state_q == LD_DONE) begin
            if (reload_i) begin
                byte_idx_q <= '0;
                word_cnt_q <= '0;
                words_q    <= '0;
                err_q      <= 1'b0;
                cpu_rst_q  <= 1'b1;
            end
        end else begin
            if (accept && state_q == LD_LEN_LO) begin
                if (len_exceeds(hdr_n, ADDR_W)) err_q <= 1'b1;
                if (hdr_n == '0) cpu_rst_q <= 1'b0;
            end
            if (accept && state_q == LD_DATA) byte_idx_q <= byte_idx_q + 2'd1;
            if (word_acc) word_cnt_q <= word_cnt_q + 16'd1;
            if (ram_we) words_q <= words_q + 1'b1;
            if (last_word) cpu_rst_q <= 1'b0;
        end
    end

    // Header capture and big-endian byte assembly (no reset needed).
    always_ff @(posedge clk) begin
        if (accept && state_q == LD_LEN_HI) len_hi_q <= bus.byte_data_i;
        if (accept && state_q == LD_LEN_LO) len_q <= hdr_n;
        if (accept && state_q == LD_DATA)   asm_q <= {asm_q[15:0], bus.byte_data_i};
    end

    inst_rom_loader_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (words_q[ADDR_W-1:0]),
        .wdata_i ({asm_q, bus.byte_data_i}),
        .raddr_i (bus.rom_addr_i[ADDR_W+1:2]),
        .rdata_o (ram_rdata)
    );

    // Byte offset and high address bits are don't-care: fetches wrap modulo depth.
    assign unused_addr_bits = ^{bus.rom_addr_i[1:0], bus.rom_addr_i[31:ADDR_W+2]};

    assign bus.byte_ready_o = byte_ready;
    assign bus.rom_data_o   = (bus.rom_ce_i && !cpu_rst_q) ? ram_rdata : '0;
    assign cpu_rst_o        = cpu_rst_q;
    assign load_err_o       = err_q;
    assign words_loaded_o   = words_q;
endmodule
